// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_pkg
// Description : Shared definitions for the stochastic-computing stream
//               evaluator: FSM state encoding, default LFSR feedback masks
//               per supported width, and the generic LFSR next-state function.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_pkg;

    // Widest LFSR the generic next-state function handles.
    localparam int SC_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_state_e;

    // Maximal-length feedback masks for the right-shifting Fibonacci form
    // used here: bit i of the mask selects s[i] into the new MSB.
    localparam logic [3:0]  SC_TAPS_W4  = 4'b0011;              // x^4+x+1
    localparam logic [7:0]  SC_TAPS_W8  = 8'b0111_0001;         // x^8+x^6+x^5+x^4+1
    localparam logic [15:0] SC_TAPS_W16 = 16'b0110_1000_0000_0001; // x^16+x^14+x^13+x^11+1

    function automatic logic [SC_MAX_W-1:0] sc_default_taps(input int width);
        case (width)
            4:       return SC_MAX_W'(SC_TAPS_W4);
            8:       return SC_MAX_W'(SC_TAPS_W8);
            16:      return SC_MAX_W'(SC_TAPS_W16);
            default: return '0;
        endcase
    endfunction

    // next[i] = s[i+1] for i < width-1; next[width-1] = ^(s & taps).
    // Bits of s at or above width are expected to be zero.
    function automatic logic [SC_MAX_W-1:0] sc_lfsr_next(
        input logic [SC_MAX_W-1:0] s,
        input logic [SC_MAX_W-1:0] taps,
        input int                  width
    );
        logic [SC_MAX_W-1:0] msb;
        logic [SC_MAX_W-1:0] nxt;
        msb = SC_MAX_W'(1) << (width - 1);
        nxt = (s >> 1) & ~msb;
        if (^(s & taps)) begin
            nxt = nxt | msb;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : sc_lfsr
// Description : Fibonacci LFSR random source with seed load and advance
//               enable. A zero seed is replaced by 1 so the register can
//               never enter the all-zero lockup state.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous active-low reset (state -> 1)
//               load   - load seed (takes priority over en)
//               seed   - seed value
//               en     - advance one step
//               state  - current LFSR value
// Revision    : 1.0 - initial release
// ============================================================================
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(sc_default_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] next_state;

    always_comb begin
        next_state = WIDTH'(sc_lfsr_next(SC_MAX_W'(state), SC_MAX_W'(TAPS), WIDTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WIDTH'(1);
        end else if (load) begin
            state <= (seed == '0) ? WIDTH'(1) : seed;
        end else if (en) begin
            state <= next_state;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sc_stream_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : sc_stream_evaluator
// Description : Start/done controlled stochastic-computing stream engine.
//               One shared LFSR feeds NCH comparator SNGs; each channel has
//               a DEPTH-tap decorrelation delay line. An external SC logic
//               function consumes sn_x/sn_dly and returns fn_in, whose ones
//               are counted over a programmable stream length.
// Ports       : clk, rst_n       - clock, synchronous active-low reset
//               start            - start pulse, honoured in IDLE only
//               seed, inv_mask   - LFSR seed and compare XOR mask (latched)
//               thresh           - per-channel thresholds, [c*WIDTH +: WIDTH]
//               stream_len       - stream length in cycles (latched)
//               fn_in            - function result bit, counted while valid
//               sn_x             - current stochastic bits
//               sn_dly           - delayed copies, index c*DEPTH+k = k+1 cycles
//               sn_valid         - high in every RUN cycle
//               busy             - high in RUN and DONE
//               done             - one-cycle completion pulse
//               ones_cnt         - count of fn_in ones for the last stream
// Revision    : 1.0 - initial release
// ============================================================================
module sc_stream_evaluator
    import sc_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               NCH   = 4,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(sc_default_taps(WIDTH))
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       seed,
    input  logic [WIDTH-1:0]       inv_mask,
    input  logic [NCH*WIDTH-1:0]   thresh,
    input  logic [WIDTH:0]         stream_len,
    input  logic                   fn_in,
    output logic [NCH-1:0]         sn_x,
    output logic [NCH*DEPTH-1:0]   sn_dly,
    output logic                   sn_valid,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH:0]         ones_cnt
);

    localparam logic [WIDTH:0] CNT_ONE = (WIDTH+1)'(1);

    sc_state_e              state;
    logic [WIDTH-1:0]       inv_mask_q;
    logic [NCH*WIDTH-1:0]   thresh_q;
    logic [WIDTH:0]         len_q;
    logic [WIDTH:0]         cycle_cnt;

    logic [WIDTH-1:0]       lfsr_state;
    logic [WIDTH-1:0]       masked;
    logic [NCH*DEPTH-1:0]   dly_next;
    logic                   lfsr_load;
    logic                   lfsr_en;
    logic                   last_cycle;

    always_comb begin
        lfsr_load  = (state == IDLE) && start && (stream_len != '0);
        lfsr_en    = (state == RUN);
        // len_q is never zero while in RUN, so len_q-1 cannot wrap here.
        last_cycle = (cycle_cnt == (len_q - CNT_ONE));
        masked     = lfsr_state ^ inv_mask_q;
    end

    sc_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (seed),
        .en    (lfsr_en),
        .state (lfsr_state)
    );

    // Comparator SNGs; sn_valid gating forces sn_x to zero outside RUN.
    for (genvar c = 0; c < NCH; c++) begin : g_cmp
        assign sn_x[c] = sn_valid & (masked < thresh_q[c*WIDTH +: WIDTH]);
    end

    // Next value of every delay line: tap 0 takes sn_x, tap k takes tap k-1.
    for (genvar c = 0; c < NCH; c++) begin : g_dly
        assign dly_next[c*DEPTH] = sn_x[c];
        if (DEPTH > 1) begin : g_taps
            assign dly_next[c*DEPTH+1 +: DEPTH-1] = sn_dly[c*DEPTH +: DEPTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            inv_mask_q <= '0;
            thresh_q   <= '0;
            len_q      <= '0;
            cycle_cnt  <= '0;
            ones_cnt   <= '0;
            sn_dly     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sn_valid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ones_cnt <= '0;
                        busy     <= 1'b1;
                        if (stream_len != '0) begin
                            inv_mask_q <= inv_mask;
                            thresh_q   <= thresh;
                            len_q      <= stream_len;
                            cycle_cnt  <= '0;
                            sn_dly     <= '0;
                            sn_valid   <= 1'b1;
                            state      <= RUN;
                        end else begin
                            // Empty stream: report completion immediately.
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                RUN: begin
                    ones_cnt  <= ones_cnt + {{WIDTH{1'b0}}, fn_in};
                    cycle_cnt <= cycle_cnt + CNT_ONE;
                    sn_dly    <= dly_next;
                    if (last_cycle) begin
                        sn_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy     <= 1'b0;
                    sn_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_stream_evaluator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sc_stream_evaluator
// Description : Directed self-checking bench for sc_stream_evaluator with
//               WIDTH=8, NCH=4, DEPTH=2 and fn_in tied to sn_x[0].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_stream_evaluator;

    localparam int W = 8;
    localparam int N = 4;
    localparam int D = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   seed;
    logic [W-1:0]   inv_mask;
    logic [N*W-1:0] thresh;
    logic [W:0]     stream_len;
    logic           fn_in;
    logic [N-1:0]   sn_x;
    logic [N*D-1:0] sn_dly;
    logic           sn_valid;
    logic           busy;
    logic           done;
    logic [W:0]     ones_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign fn_in = sn_x[0];

    sc_stream_evaluator #(
        .WIDTH (W),
        .NCH   (N),
        .DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .inv_mask   (inv_mask),
        .thresh     (thresh),
        .stream_len (stream_len),
        .fn_in      (fn_in),
        .sn_x       (sn_x),
        .sn_dly     (sn_dly),
        .sn_valid   (sn_valid),
        .busy       (busy),
        .done       (done),
        .ones_cnt   (ones_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent reference LFSR step for the default 8-bit taps (6,5,4,0).
    function automatic logic [7:0] model_step(input logic [7:0] s);
        return {^(s & 8'b0111_0001), s[7:1]};
    endfunction

    // Runs one stream, checking sn_x and sn_dly every RUN cycle against the
    // reference model. Cycle numbers are relative to the start edge E.
    task automatic run_stream(
        input  logic [7:0]  sd,
        input  logic [7:0]  inv,
        input  logic [31:0] thr,
        input  logic [8:0]  len,
        input  int          poke_at,
        output int          ones,
        output int          mones,
        output int          done_at,
        output int          nvalid,
        output int          xerr,
        output int          derr,
        output int          distinct
    );
        logic [7:0] m;
        logic [3:0] ex;
        logic [3:0] h1;
        logic [3:0] h2;
        logic [7:0] exd;
        logic [7:0] st;
        bit         seen [256];
        m        = (sd == 8'd0) ? 8'd1 : sd;
        h1       = '0;
        h2       = '0;
        xerr     = 0;
        derr     = 0;
        nvalid   = 0;
        distinct = 0;
        mones    = 0;
        done_at  = -1;
        ones     = -1;
        foreach (seen[i]) seen[i] = 1'b0;
        @(negedge clk);
        seed       = sd;
        inv_mask   = inv;
        thresh     = thr;
        stream_len = len;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= int'(len) + 4; cyc++) begin
            start = 1'b0;
            if (done) begin
                done_at = cyc;
                ones    = int'(ones_cnt);
                break;
            end
            if (sn_valid) begin
                for (int c = 0; c < 4; c++) begin
                    ex[c]       = ((m ^ inv) < thr[c*8 +: 8]);
                    exd[c*2]    = h1[c];
                    exd[c*2+1]  = h2[c];
                end
                if (sn_x !== ex) xerr++;
                if (sn_dly !== exd) derr++;
                st = dut.u_lfsr.state;
                if (!seen[st]) begin
                    seen[st] = 1'b1;
                    distinct++;
                end
                if (ex[0]) mones++;
                h2 = h1;
                h1 = ex;
                m  = model_step(m);
                if (nvalid == poke_at) begin
                    // Start with different config mid-RUN must be ignored.
                    start    = 1'b1;
                    seed     = 8'h33;
                    thresh   = '0;
                    inv_mask = 8'hFF;
                end
                nvalid++;
            end else if (sn_x !== 4'd0) begin
                xerr++;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        check_val({tag, "_done_low"}, 32'(done), 32'd0);
        check_val({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    int ones, mones, done_at, nvalid, xerr, derr, distinct;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        seed       = '0;
        inv_mask   = '0;
        thresh     = '0;
        stream_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_valid", 32'(sn_valid), 32'd0);
        check_val("rst_sn_x", 32'(sn_x), 32'd0);
        check_val("rst_dly", 32'(sn_dly), 32'd0);
        check_val("rst_ones", 32'(ones_cnt), 32'd0);
        check_val("rst_lfsr", 32'(dut.u_lfsr.state), 32'd1);
        rst_n = 1'b1;

        // Full period, mid threshold on channel 0.
        run_stream(8'h01, 8'h00, 32'h40C0FF80, 9'd255, -1, ones, mones, done_at, nvalid, xerr, derr, distinct);
        check_val("s1_ones", ones, 32'd127);
        check_val("s1_done_at", done_at, 32'd256);
        check_val("s1_nvalid", nvalid, 32'd255);
        check_val("s1_distinct", distinct, 32'd255);
        check_val("s1_sn_x", xerr, 32'd0);
        check_val("s1_dly", derr, 32'd0);
        check_idle_after("s1");

        // Threshold extremes.
        run_stream(8'h01, 8'h00, 32'h00000000, 9'd255, -1, ones, mones, done_at, nvalid, xerr, derr, distinct);
        check_val("s2lo_ones", ones, 32'd0);
        check_val("s2lo_sn_x", xerr, 32'd0);
        run_stream(8'h01, 8'h00, 32'h123456FF, 9'd255, -1, ones, mones, done_at, nvalid, xerr, derr, distinct);
        check_val("s2hi_ones", ones, 32'd254);
        check_val("s2hi_sn_x", xerr, 32'd0);
        check_val("s2hi_dly", derr, 32'd0);

        // Inversion mask.
        run_stream(8'h01, 8'h80, 32'h20A0E080, 9'd255, -1, ones, mones, done_at, nvalid, xerr, derr, distinct);
        check_val("s3_ones", ones, 32'd128);
        check_val("s3_sn_x", xerr, 32'd0);

        // Short stream from a non-trivial seed, model-derived count.
        run_stream(8'hA5, 8'h3C, 32'h1060A0E0, 9'd20, -1, ones, mones, done_at, nvalid, xerr, derr, distinct);
        check_val("short_ones", ones, mones);
        check_val("short_done_at", done_at, 32'd21);
        check_val("short_sn_x", xerr, 32'd0);
        check_val("short_dly", derr, 32'd0);
        check_idle_after("short");

        // Zero seed behaves as seed 1.
        run_stream(8'h00, 8'h00, 32'h40C0FF80, 9'd255, -1, ones, mones, done_at, nvalid, xerr, derr, distinct);
        check_val("s5_seed0_ones", ones, 32'd127);
        check_val("s5_seed0_sn_x", xerr, 32'd0);
        check_val("s5_seed0_distinct", distinct, 32'd255);

        // Zero-length stream; ones_cnt currently holds 127 so clearing shows.
        run_stream(8'h01, 8'h00, 32'h000000FF, 9'd0, -1, ones, mones, done_at, nvalid, xerr, derr, distinct);
        check_val("s5_len0_done_at", done_at, 32'd1);
        check_val("s5_len0_ones", ones, 32'd0);
        check_val("s5_len0_nvalid", nvalid, 32'd0);
        check_idle_after("s5_len0");

        // Start pulsed during RUN is ignored.
        run_stream(8'h01, 8'h00, 32'h40C0FF80, 9'd255, 10, ones, mones, done_at, nvalid, xerr, derr, distinct);
        check_val("s5_poke_ones", ones, 32'd127);
        check_val("s5_poke_done_at", done_at, 32'd256);
        check_val("s5_poke_sn_x", xerr, 32'd0);
        check_idle_after("s5_poke");

        // Reset mid-stream at RUN cycle 50.
        @(negedge clk);
        seed       = 8'h01;
        inv_mask   = 8'h00;
        thresh     = 32'h40C0FF80;
        stream_len = 9'd255;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check_val("s6_pre_valid", 32'(sn_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("s6_busy", 32'(busy), 32'd0);
        check_val("s6_done", 32'(done), 32'd0);
        check_val("s6_valid", 32'(sn_valid), 32'd0);
        check_val("s6_dly", 32'(sn_dly), 32'd0);
        check_val("s6_ones", 32'(ones_cnt), 32'd0);
        check_val("s6_state", 32'(dut.state), 32'd0);
        check_val("s6_lfsr", 32'(dut.u_lfsr.state), 32'd1);
        run_stream(8'h01, 8'h00, 32'h40C0FF80, 9'd255, -1, ones, mones, done_at, nvalid, xerr, derr, distinct);
        check_val("s6_rerun_ones", ones, 32'd127);
        check_val("s6_rerun_done_at", done_at, 32'd256);
        check_val("s6_rerun_sn_x", xerr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
